// File: rtl/execution_trace_buffer.sv
// Snapshots r0..r7 into an in-order trace FIFO on each entry into FETCH_END and
// drains it over a valid/ready port; dropped events are counted, not hidden.
package constants_pkg;
  typedef enum logic [2:0] {
    FETCH_START = 3'd0,
    FETCH_END   = 3'd1,
    DECODE      = 3'd2,
    EXECUTE     = 3'd3,
    MEMORY      = 3'd4,
    WRITEBACK   = 3'd5
  } ExecutionStage;
endpackage

module execution_trace_buffer #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  constants_pkg::ExecutionStage  state,
  input  logic [7:0]                    r0,
  input  logic [7:0]                    r1,
  input  logic [7:0]                    r2,
  input  logic [7:0]                    r3,
  input  logic [7:0]                    r4,
  input  logic [7:0]                    r5,
  input  logic [7:0]                    r6,
  input  logic [7:0]                    r7,
  input  logic                          capture_en,
  input  logic                          trace_ready,
  output logic                          trace_valid,
  output logic [IDX_W-1:0]              trace_index,
  output logic [63:0]                   trace_regs,
  output logic [$clog2(DEPTH+1)-1:0]    level,
  output logic [7:0]                    drop_count,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  logic              r_prev_fe;
  logic [IDX_W-1:0]  r_idx;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [7:0]        r_drop;
  logic              r_ovf;
  logic [IDX_W-1:0]  r_mem_idx  [DEPTH];
  logic [63:0]       r_mem_regs [DEPTH];

  logic w_is_fe;
  logic w_event;
  logic w_pop;
  logic w_push;
  logic w_drop;

  always_comb begin
    w_is_fe = (state == constants_pkg::FETCH_END);
    w_event = capture_en && w_is_fe && !r_prev_fe;
    w_pop   = (r_level != '0) && trace_ready;
    // A full FIFO still accepts the event when the head leaves in the same cycle.
    w_push  = w_event && ((r_level < FULL) || w_pop);
    w_drop  = w_event && !w_push;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_fe <= 1'b0;
      r_idx     <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_drop    <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_prev_fe <= w_is_fe;
      if (w_event) r_idx <= r_idx + 1'b1;
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_push && w_pop) r_level <= r_level - 1'b1;
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != '1) r_drop <= r_drop + 1'b1;
      end
    end
  end

  // Storage is deliberately not reset; only occupancy tracking is.
  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_mem_idx[r_wr_ptr]  <= r_idx;
      r_mem_regs[r_wr_ptr] <= {r7, r6, r5, r4, r3, r2, r1, r0};
    end
  end

  always_comb begin
    trace_valid = (r_level != '0);
    trace_index = r_mem_idx[r_rd_ptr];
    trace_regs  = r_mem_regs[r_rd_ptr];
    level       = r_level;
    drop_count  = r_drop;
    overflow    = r_ovf;
  end

endmodule

// File: tb/tb_execution_trace_buffer.sv
// Randomized and directed stimulus for execution_trace_buffer, checked every
// cycle against a queue-based reference model.
module tb_execution_trace_buffer;
  import constants_pkg::*;

  localparam int DEPTH = 16;
  localparam int IDX_W = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  ExecutionStage        st;
  logic [7:0]           r [8];
  logic                 cap;
  logic                 rdy;
  logic                 trace_valid;
  logic [IDX_W-1:0]     trace_index;
  logic [63:0]          trace_regs;
  logic [4:0]           level;
  logic [7:0]           drop_count;
  logic                 overflow;

  execution_trace_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .state(st),
    .r0(r[0]), .r1(r[1]), .r2(r[2]), .r3(r[3]),
    .r4(r[4]), .r5(r[5]), .r6(r[6]), .r7(r[7]),
    .capture_en(cap), .trace_ready(rdy),
    .trace_valid(trace_valid), .trace_index(trace_index), .trace_regs(trace_regs),
    .level(level), .drop_count(drop_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IDX_W-1:0] idx; logic [63:0] regs; } entry_t;

  entry_t           m_q[$];
  logic [IDX_W-1:0] m_idx;
  logic             m_prev;
  int unsigned      m_drop;
  logic             m_ovf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic   ev;
    entry_t e;
    if (reset) begin
      m_q.delete();
      m_idx  = '0;
      m_prev = 1'b0;
      m_drop = 0;
      m_ovf  = 1'b0;
    end else begin
      ev = cap && (st == FETCH_END) && !m_prev;
      if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
      if (ev) begin
        if (m_q.size() < DEPTH) begin
          e.idx  = m_idx;
          e.regs = {r[7], r[6], r[5], r[4], r[3], r[2], r[1], r[0]};
          m_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 255) m_drop++;
        end
        m_idx = m_idx + 1'b1;
      end
      m_prev = (st == FETCH_END);
    end
  endtask

  task automatic compare_all();
    chk("valid", 64'(trace_valid), 64'(m_q.size() != 0));
    chk("level", 64'(level), 64'(m_q.size()));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    if (m_q.size() != 0) begin
      chk("trace_index", 64'(trace_index), 64'(m_q[0].idx));
      chk("trace_regs", trace_regs, m_q[0].regs);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    st    = DECODE;
    cycle();
    reset = 1'b0;
  endtask

  // One capture event carrying r0=v, followed by a non-FETCH_END cycle.
  task automatic fire(input logic [7:0] v);
    st   = FETCH_END;
    r[0] = v;
    cycle();
    st = EXECUTE;
    cycle();
  endtask

  initial begin
    reset = 1'b1; st = DECODE; cap = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 8; i++) r[i] = '0;
    cycle();
    do_reset();
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);

    // Single event, consumer ready
    for (int i = 0; i < 8; i++) r[i] = 8'(i + 1);
    rdy = 1'b1; st = FETCH_END;
    cycle();
    chk("t1_valid", 64'(trace_valid), 64'd1);
    chk("t1_index", 64'(trace_index), 64'd0);
    chk("t1_regs", trace_regs, 64'h0807060504030201);
    chk("t1_level", 64'(level), 64'd1);
    st = DECODE;
    cycle();
    chk("t1_valid_after", 64'(trace_valid), 64'd0);
    chk("t1_level_after", 64'(level), 64'd0);

    // Held FETCH_END yields one event
    do_reset();
    rdy = 1'b0;
    st = FETCH_END; repeat (3) cycle();
    st = DECODE; cycle();
    st = FETCH_END; cycle();
    st = DECODE; cycle();
    chk("t2_level", 64'(level), 64'd2);
    chk("t2_head0", 64'(trace_index), 64'd0);
    rdy = 1'b1; cycle();
    chk("t2_head1", 64'(trace_index), 64'd1);
    cycle();
    chk("t2_empty", 64'(trace_valid), 64'd0);

    // Overflow with 17 events
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 17; i++) fire(8'(i));
    chk("t3_level", 64'(level), 64'd16);
    chk("t3_drop", 64'(drop_count), 64'd1);
    chk("t3_ovf", 64'(overflow), 64'd1);
    rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain_idx", 64'(trace_index), 64'(i));
      chk("t3_drain_r0", 64'(trace_regs[7:0]), 64'(i));
      cycle();
    end
    chk("t3_drained", 64'(level), 64'd0);
    st = FETCH_END; cycle();
    chk("t3_next_idx", 64'(trace_index), 64'd17);
    st = DECODE; cycle();

    // Full FIFO, event and pop in the same cycle
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 16; i++) fire(8'(i));
    st = FETCH_END; r[0] = 8'hAA; rdy = 1'b1;
    cycle();
    chk("t4_drop", 64'(drop_count), 64'd0);
    chk("t4_level", 64'(level), 64'd16);
    st = DECODE;
    repeat (15) cycle();
    chk("t4_last_idx", 64'(trace_index), 64'd16);
    chk("t4_last_r0", 64'(trace_regs[7:0]), 64'hAA);
    cycle();

    // capture_en low
    do_reset();
    cap = 1'b0; rdy = 1'b0;
    for (int i = 0; i < 4; i++) fire(8'(i));
    chk("t5_level", 64'(level), 64'd0);
    cap = 1'b1;
    st = FETCH_END; cycle();
    chk("t5_idx", 64'(trace_index), 64'd0);
    st = DECODE; cycle();

    // Mid-operation reset
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 17; i++) fire(8'(i));
    rdy = 1'b1; repeat (11) cycle();
    rdy = 1'b0; cycle();
    chk("t6_level5", 64'(level), 64'd5);
    chk("t6_ovf1", 64'(overflow), 64'd1);
    reset = 1'b1; st = FETCH_END; cycle();
    reset = 1'b0;
    chk("t6_valid", 64'(trace_valid), 64'd0);
    chk("t6_level", 64'(level), 64'd0);
    chk("t6_drop", 64'(drop_count), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    st = DECODE; cycle();
    st = FETCH_END; cycle();
    chk("t6_idx", 64'(trace_index), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      st    = ExecutionStage'(3'($urandom_range(0, 5)));
      if ($urandom_range(0, 2) == 0) st = FETCH_END;
      cap   = ($urandom_range(0, 9) != 0);
      rdy   = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 8; i++) r[i] = 8'($urandom);
      cycle();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
